// File: rtl/pe_buffer_sequencer_if.sv
// ---------------------------------------------------------------------------
// pe_buffer_sequencer_if
//
// Purpose: bundles the control, circular-buffer, MAC and psum handshake
// signals between the PE buffer sequencer and the rest of the PE.
//
// Signals:
//   start, abort        job control from the PE controller
//   num_out             number of psums in the job (CNT_WIDTH bits)
//   ifmap_valid         ifmap circular buffer is not empty
//   filt_valid          filter circular buffer is not empty
//   psum_ready          downstream psum logic can accept a psum
//   ifmap_read_en       pop one ifmap element
//   filt_read_en        pop one filter element
//   mac_en, acc_clr     multiply-accumulate enable / accumulator load
//   psum_write_en       accumulator holds a finished psum
//   busy, done          job status
//
// Modports:
//   master  the sequencer (drives enables and status)
//   slave   buffers, datapath and job controller around it
// ---------------------------------------------------------------------------
interface pe_buffer_sequencer_if #(
  parameter int CNT_WIDTH = 8
);

  logic                 start;
  logic                 abort;
  logic [CNT_WIDTH-1:0] num_out;
  logic                 ifmap_valid;
  logic                 filt_valid;
  logic                 psum_ready;
  logic                 ifmap_read_en;
  logic                 filt_read_en;
  logic                 mac_en;
  logic                 acc_clr;
  logic                 psum_write_en;
  logic                 busy;
  logic                 done;

  modport master (
    input  start,
    input  abort,
    input  num_out,
    input  ifmap_valid,
    input  filt_valid,
    input  psum_ready,
    output ifmap_read_en,
    output filt_read_en,
    output mac_en,
    output acc_clr,
    output psum_write_en,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output num_out,
    output ifmap_valid,
    output filt_valid,
    output psum_ready,
    input  ifmap_read_en,
    input  filt_read_en,
    input  mac_en,
    input  acc_clr,
    input  psum_write_en,
    input  busy,
    input  done
  );

endinterface

// File: rtl/pe_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// pe_buffer_sequencer
//
// Purpose: sequences one processing element's filter and ifmap circular
// buffers into its MAC datapath. For each of num_out psums it pops FILT_LEN
// matched filter/ifmap pairs, drives mac_en/acc_clr one cycle after each pop
// (buffer data arrives the cycle after the read), waits one DRAIN cycle for
// the last MAC, then offers the psum downstream until psum_ready is seen.
//
// Parameters:
//   FILT_LEN   elements per filter window (MACs per psum), 1..2^CNT_WIDTH-1
//   CNT_WIDTH  width of element counter, output counter and num_out
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   seq   pe_buffer_sequencer_if.master (control, buffer, MAC, psum signals)
// ---------------------------------------------------------------------------
module pe_buffer_sequencer #(
  parameter int FILT_LEN  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  pe_buffer_sequencer_if.master   seq
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_ELEM = CNT_WIDTH'(FILT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] elem_cnt;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic [CNT_WIDTH-1:0] num_out_q;
  logic                 mac_en_q;
  logic                 acc_clr_q;
  logic                 pop;
  logic                 window_last;
  logic                 job_last;
  logic                 cancel;

  // Abort only has an effect once a job is in flight.
  assign cancel      = seq.abort && (state != IDLE);
  assign window_last = (elem_cnt == LAST_ELEM);
  assign job_last    = (out_cnt == (num_out_q - CNT_ONE));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Abort overrides every transition out of a busy state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (seq.start) begin
          state_nxt = (seq.num_out == CNT_ZERO) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pop && window_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        if (seq.psum_ready) begin
          state_nxt = job_last ? DONE : RUN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (cancel) begin
      state_nxt = IDLE;
    end
  end

  // Output logic. Read enables are combinational so a pop happens in the
  // same cycle both buffers report data; they are suppressed during abort.
  always_comb begin
    pop               = 1'b0;
    if ((state == RUN) && !seq.abort) begin
      pop = seq.ifmap_valid && seq.filt_valid;
    end
    seq.ifmap_read_en = pop;
    seq.filt_read_en  = pop;
    seq.mac_en        = mac_en_q;
    seq.acc_clr       = acc_clr_q;
    seq.psum_write_en = (state == WRITE);
    seq.busy          = (state != IDLE);
    seq.done          = (state == DONE);
  end

  // Counters and MAC controls. mac_en trails its pop by one cycle because
  // popped data is valid the following cycle; an in-flight mac_en still
  // fires after an abort since the data has already left the buffers.
  // acc_clr marks the first pair of each window so the accumulator loads
  // instead of adding to the previous psum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elem_cnt  <= '0;
      out_cnt   <= '0;
      num_out_q <= '0;
      mac_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      mac_en_q  <= pop;
      acc_clr_q <= pop && (elem_cnt == CNT_ZERO);
      if (cancel) begin
        elem_cnt <= '0;
        out_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (seq.start) begin
              num_out_q <= seq.num_out;
              elem_cnt  <= '0;
              out_cnt   <= '0;
            end
          end
          RUN: begin
            if (pop) begin
              elem_cnt <= window_last ? CNT_ZERO : (elem_cnt + CNT_ONE);
            end
          end
          WRITE: begin
            if (seq.psum_ready && !job_last) begin
              out_cnt <= out_cnt + CNT_ONE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pe_buffer_sequencer
//
// Directed bench for pe_buffer_sequencer (FILT_LEN=4). Each scenario pushes
// its hand-derived per-cycle output pattern into a scoreboard queue, then
// drives the job; a monitor on the falling edge pops one entry per cycle
// and compares it with the DUT outputs. Cycle 1 is the cycle right after
// the edge that accepts start.
// ---------------------------------------------------------------------------
module tb_pe_buffer_sequencer;

  localparam int FILT_LEN  = 4;
  localparam int CNT_WIDTH = 8;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  logic check_on;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  pe_buffer_sequencer_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  pe_buffer_sequencer #(
    .FILT_LEN (FILT_LEN),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seq(bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit c of the returned mask is set for every cycle c in lo..hi.
  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Queue expected vectors {ifmap_rd, filt_rd, mac_en, acc_clr, psum_wr,
  // busy, done} for cycles 1..len from per-signal cycle masks.
  task automatic pushExpected(input string tag, input int len,
                              input logic [31:0] rd_m, input logic [31:0] mac_m,
                              input logic [31:0] clr_m, input logic [31:0] wr_m,
                              input logic [31:0] busy_m, input logic [31:0] done_m);
    exp_t e;
    for (int c = 1; c <= len; c++) begin
      e.name = $sformatf("%s_c%0d", tag, c);
      e.exp  = {rd_m[c], rd_m[c], mac_m[c], clr_m[c], wr_m[c], busy_m[c], done_m[c]};
      sb_q.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input logic [6:0] act,
                             input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b (ird,frd,mac,clr,wr,busy,done)",
               name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per cycle while a scenario is active.
  always @(negedge clk) begin
    exp_t e;
    if (check_on && (sb_q.size() > 0)) begin
      e = sb_q.pop_front();
      checkOutput(e.name,
                  {bus.ifmap_read_en, bus.filt_read_en, bus.mac_en, bus.acc_clr,
                   bus.psum_write_en, bus.busy, bus.done},
                  e.exp);
    end
  end

  // Wait (bounded) for the monitor to drain the scoreboard.
  task automatic drainScoreboard(input string tag);
    for (int k = 0; (k < 6) && (sb_q.size() > 0); k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: %0d entries left, expected 0", tag, sb_q.size());
      sb_q.delete();
    end
    check_on = 1'b0;
  endtask

  // Start a job of n psums and drive len cycles. filt_valid is low in
  // stall_lo..stall_hi, psum_ready low in rdy_lo..rdy_hi, abort high in
  // abort_at, and rst pulses low mid-cycle in rst_at (released mid-cycle
  // in rst_at+1). Unused windows use -1.
  task automatic applyStimulus(input string tag, input int n, input int len,
                               input int stall_lo, input int stall_hi,
                               input int rdy_lo, input int rdy_hi,
                               input int abort_at, input int rst_at);
    @(posedge clk); #1;
    bus.num_out     = CNT_WIDTH'(n);
    bus.start       = 1'b1;
    bus.ifmap_valid = 1'b1;
    bus.filt_valid  = 1'b1;
    bus.psum_ready  = 1'b1;
    bus.abort       = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_on  = 1'b1;
    for (int c = 1; c <= len; c++) begin
      bus.filt_valid = !((c >= stall_lo) && (c <= stall_hi));
      bus.psum_ready = !((c >= rdy_lo) && (c <= rdy_hi));
      bus.abort      = (c == abort_at);
      if (c == rst_at) begin
        #1 rst = 1'b0;
      end
      if (c == rst_at + 1) begin
        #1 rst = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.abort      = 1'b0;
    bus.filt_valid = 1'b1;
    bus.psum_ready = 1'b1;
    drainScoreboard(tag);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    check_on        = 1'b0;
    rst             = 1'b0;
    bus.start       = 1'b1;
    bus.abort       = 1'b0;
    bus.num_out     = 8'd3;
    bus.ifmap_valid = 1'b1;
    bus.filt_valid  = 1'b1;
    bus.psum_ready  = 1'b1;

    // Reset state: everything low even with start and both valids high.
    pushExpected("reset", 2, '0, '0, '0, '0, '0, '0);
    check_on = 1'b1;
    drainScoreboard("reset");
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Three psums, free-flowing: windows every 6 cycles, done in cycle 19.
    pushExpected("full", 20,
                 span(1, 4) | span(7, 10) | span(13, 16),
                 span(2, 5) | span(8, 11) | span(14, 17),
                 span(2, 2) | span(8, 8) | span(14, 14),
                 span(6, 6) | span(12, 12) | span(18, 18),
                 span(1, 19), span(19, 19));
    applyStimulus("full", 3, 20, -1, -1, -1, -1, -1, -1);

    // Empty job: straight to DONE, busy for one cycle, no reads.
    pushExpected("zero", 2, '0, '0, '0, '0, span(1, 1), span(1, 1));
    applyStimulus("zero", 0, 2, -1, -1, -1, -1, -1, -1);

    // filt_valid stall at the second element: window ends 3 cycles late.
    pushExpected("stall", 11,
                 span(1, 1) | span(5, 7), span(2, 2) | span(6, 8),
                 span(2, 2), span(9, 9), span(1, 10), span(10, 10));
    applyStimulus("stall", 1, 11, 2, 4, -1, -1, -1, -1);

    // Backpressure: ready low 5 cycles in WRITE, second psum follows.
    pushExpected("bp", 19,
                 span(1, 4) | span(12, 15), span(2, 5) | span(13, 16),
                 span(2, 2) | span(13, 13), span(6, 11) | span(17, 17),
                 span(1, 18), span(18, 18));
    applyStimulus("bp", 2, 19, -1, -1, 6, 10, -1, -1);

    // Abort after two pops: trailing mac_en in the abort cycle, no done.
    pushExpected("abort", 4, span(1, 2), span(2, 3), span(2, 2), '0,
                 span(1, 3), '0);
    applyStimulus("abort", 1, 4, -1, -1, -1, -1, 3, -1);

    // A normal single-psum job right after the abort.
    pushExpected("post_abort", 8, span(1, 4), span(2, 5), span(2, 2),
                 span(6, 6), span(1, 7), span(7, 7));
    applyStimulus("post_abort", 1, 8, -1, -1, -1, -1, -1, -1);

    // Asynchronous reset in cycle 3: outputs drop at once, stay idle.
    pushExpected("arst", 5, span(1, 2), span(2, 2), span(2, 2), '0,
                 span(1, 2), '0);
    applyStimulus("arst", 2, 5, -1, -1, -1, -1, -1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
